// File: rtl/ysyx_22050854_pkg.sv
// ysyx_22050854_pkg: ALU opcodes, ID/EX entry struct and pipeline-register state enum
package ysyx_22050854_pkg;
  localparam int XLEN_MAX = 64;
  localparam logic [3:0] ALU_ADD       = 4'b0000;
  localparam logic [3:0] ALU_SLL       = 4'b0001;
  localparam logic [3:0] ALU_SUB       = 4'b0010;
  localparam logic [3:0] ALU_PASS_SRC2 = 4'b0011;
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [3:0]          aluctr;
    logic [XLEN_MAX-1:0] src1;
    logic [XLEN_MAX-1:0] src2;
    logic [4:0]          rd;
    logic                wen;
  } idex_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
endpackage

// File: rtl/ysyx_22050854_skid_buf.sv
// ysyx_22050854_skid_buf: two-entry skid buffer; in_ready comes only from state flops
module ysyx_22050854_skid_buf
  import ysyx_22050854_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  state_t       state, state_n;
  logic [W-1:0] skid;
  logic         acc, ret;
  // handshakes and next state; flush overrides every transition
  always_comb begin
    in_ready  = state != FULL;
    out_valid = state != EMPTY;
    acc       = in_valid && in_ready;
    ret       = out_valid && out_ready;
    state_n   = state;
    if (flush) state_n = EMPTY;
    else if (state == EMPTY) state_n = acc ? BUSY : EMPTY;
    else if (state == BUSY) state_n = (acc && !ret) ? FULL : (ret && !acc) ? EMPTY : BUSY;
    else state_n = ret ? BUSY : FULL;
  end
  // state, main (output) register and skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      skid     <= '0;
    end else begin
      state <= state_n;
      if (!flush && acc && (state == EMPTY || (state == BUSY && ret))) out_data <= in_data;
      else if (!flush && state == FULL && ret) out_data <= skid;
      if (!flush && acc && state == BUSY && !ret) skid <= in_data;
    end
  end
endmodule

// File: rtl/ysyx_22050854_idex_reg.sv
// ysyx_22050854_idex_reg: ID/EX pipeline register with valid/ready handshake and stall counter
// YSYX_22050854_IDEX_SKID_EN defined: two-entry skid buffer, registered in_ready
module ysyx_22050854_idex_reg
  import ysyx_22050854_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [3:0]      in_aluctr,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_aluctr,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [31:0]     stall_cnt
);
  idex_t in_e, out_e;
  assign in_e       = '{pc: XLEN_MAX'(in_pc), aluctr: in_aluctr, src1: XLEN_MAX'(in_src1),
                        src2: XLEN_MAX'(in_src2), rd: in_rd, wen: in_wen};
  assign out_pc     = out_e.pc[XLEN-1:0];
  assign out_aluctr = out_e.aluctr;
  assign out_src1   = out_e.src1[XLEN-1:0];
  assign out_src2   = out_e.src2[XLEN-1:0];
  assign out_rd     = out_e.rd;
  assign out_wen    = out_e.wen;
`ifdef YSYX_22050854_IDEX_SKID_EN
  ysyx_22050854_skid_buf #(.W($bits(idex_t))) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_e),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_e)
  );
`else
  state_t state, state_n;
  logic   acc, ret;
  // single-entry register: accept whenever empty or being drained this cycle
  always_comb begin
    out_valid = state == BUSY;
    in_ready  = !out_valid || out_ready;
    acc       = in_valid && in_ready;
    ret       = out_valid && out_ready;
    state_n   = flush ? EMPTY : acc ? BUSY : ret ? EMPTY : state;
  end
  // state and held entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_e <= '0;
    end else begin
      state <= state_n;
      if (acc && !flush) out_e <= in_e;
    end
  end
`endif
  // cycles where execute holds off a presented entry; flush does not affect it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_ysyx_22050854_idex_reg.sv
// tb_ysyx_22050854_idex_reg: random and directed checks against a queue-based reference model
module tb_ysyx_22050854_idex_reg;
  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  alu;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0, in_wen = 0;
  logic [63:0] in_pc = 0, in_src1 = 0, in_src2 = 0;
  logic [3:0]  in_aluctr = 0;
  logic [4:0]  in_rd = 0;
  logic        in_ready, out_valid, out_wen;
  logic [63:0] out_pc, out_src1, out_src2;
  logic [3:0]  out_aluctr;
  logic [4:0]  out_rd;
  logic [31:0] stall_cnt;
  int          tests = 0, fails = 0;
  ent_t        q[$];
  logic [31:0] m_cnt = 0;
`ifdef YSYX_22050854_IDEX_SKID_EN
  localparam bit SKID = 1;
`else
  localparam bit SKID = 0;
`endif

  ysyx_22050854_idex_reg #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_aluctr(in_aluctr), .in_src1(in_src1), .in_src2(in_src2),
    .in_rd(in_rd), .in_wen(in_wen), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_aluctr(out_aluctr), .out_src1(out_src1), .out_src2(out_src2),
    .out_rd(out_rd), .out_wen(out_wen), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc  = {$urandom, $urandom};
    e.alu = 4'($urandom_range(0, 3));
    e.s1  = {$urandom, $urandom};
    e.s2  = {$urandom, $urandom};
    e.rd  = 5'($urandom);
    e.wen = 1'($urandom);
    return e;
  endfunction

  function automatic logic exp_ready();
    return SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
  endfunction

  task automatic step(input ent_t e, input logic v, input logic ordy, input logic fl);
    logic rdy;
    @(negedge clk);
    in_valid = v; out_ready = ordy; flush = fl;
    in_pc = e.pc; in_aluctr = e.alu; in_src1 = e.s1; in_src2 = e.s2; in_rd = e.rd; in_wen = e.wen;
    #1;
    rdy = exp_ready();
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, q.size() > 0);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_aluctr", out_aluctr, q[0].alu);
      chk("out_src1", out_src1, q[0].s1);
      chk("out_src2", out_src2, q[0].s2);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_wen", out_wen, q[0].wen);
    end
    @(posedge clk);
    if (q.size() > 0 && !ordy) m_cnt++;
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && rdy) q.push_back(e);
    end
  endtask

  initial begin
    ent_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_src1", out_src1, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    e = '{pc: 64'h8000_0000, alu: 4'b0000, s1: 64'd5, s2: 64'd7, rd: 5'd3, wen: 1'b1};
    step(e, 1, 1, 0);
    step(rnd_ent(), 0, 1, 0);
    step(rnd_ent(), 0, 1, 0);
    for (int i = 0; i < 8; i++) step(rnd_ent(), 1, 1, 0);
    step(rnd_ent(), 0, 1, 0);
    step(rnd_ent(), 0, 1, 0);
    for (int i = 0; i < 4; i++) step(rnd_ent(), 1, 0, 0);
    #1;
    chk("stall3", stall_cnt, 32'd3);
    for (int i = 0; i < 3; i++) step(rnd_ent(), 0, 1, 0);
    step(rnd_ent(), 1, 0, 0);
    step(rnd_ent(), 1, 0, 0);
    step(rnd_ent(), 1, 1, 1);
    step(rnd_ent(), 0, 1, 0);
    step(rnd_ent(), 0, 1, 0);
    step(rnd_ent(), 1, 0, 0);
    step(rnd_ent(), 0, 0, 0);
    #3;
    rst_n = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_out_pc", out_pc, 0);
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1;
    step(rnd_ent(), 1, 0, 0);
    #2;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    step(rnd_ent(), 0, 0, 0);
    #1;
    chk("stall_wrap", stall_cnt, 0);
    step(rnd_ent(), 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step(rnd_ent(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0));
    for (int i = 0; i < 3; i++) step(rnd_ent(), 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
